// File: rtl/alu_share_arbiter.sv
// Two-requester valid/ready arbiter in front of one shared external ALU; one op in flight.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins (default: round robin).
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_aluc,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_aluc,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_aluc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   grant1_s;
    logic   accept_s;
    logic   id_r;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic   last_grant_r;
`endif

    // Winner selection; on contention the requester not granted last time wins
    always_comb begin
        grant1_s = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant1_s = req1_valid & ~req0_valid;
`else
        grant1_s = req1_valid & (~req0_valid | ~last_grant_r);
`endif
    end

    assign req0_ready = (state_r == IDLE) & req0_valid & ~grant1_s;
    assign req1_ready = (state_r == IDLE) & grant1_s;
    assign accept_s   = req0_ready | req1_ready;

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = EXEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC: next_state_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Round-robin history; starts at 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            last_grant_r <= grant1_s;
        end
    end
`endif

    // Operand capture on accept, result capture in EXEC, response handshake in RESP
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            alu_aluc  <= 4'd0;
            alu_a     <= '0;
            alu_b     <= '0;
            id_r      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_r     <= '0;
            rsp_z     <= 1'b0;
        end else begin
            if (accept_s) begin
                alu_aluc <= grant1_s ? req1_aluc : req0_aluc;
                alu_a    <= grant1_s ? req1_a    : req0_a;
                alu_b    <= grant1_s ? req1_b    : req0_b;
                id_r     <= grant1_s;
            end
            // rsp_id follows the result, so all rsp_* fields change together
            if (state_r == EXEC) begin
                rsp_r     <= alu_r;
                rsp_z     <= alu_z;
                rsp_id    <= id_r;
                rsp_valid <= 1'b1;
            end else if ((state_r == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed, table-driven bench for alu_share_arbiter with a behavioural ALU model in the loop.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             clrn;
    logic             req0_valid, req0_ready;
    logic [3:0]       req0_aluc;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [3:0]       req1_aluc;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [3:0]       alu_aluc;
    logic [WIDTH-1:0] alu_a, alu_b, alu_r;
    logic             alu_z;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_z;
    logic [WIDTH-1:0] rsp_r;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .clrn(clrn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluc(req0_aluc),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluc(req1_aluc),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_aluc(alu_aluc), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .rsp_z(rsp_z)
    );

    // Shared ALU model
    always_comb begin
        case (alu_aluc)
            4'b0000: alu_r = alu_a + alu_b;
            4'b0100: alu_r = alu_a - alu_b;
            4'b0001: alu_r = alu_a & alu_b;
            4'b0101: alu_r = alu_a | alu_b;
            4'b0010: alu_r = alu_a ^ alu_b;
            4'b0110: alu_r = {alu_b[15:0], 16'h0000};
            4'b0011: alu_r = alu_b << alu_a[4:0];
            4'b0111: alu_r = alu_b >> alu_a[4:0];
            4'b1111: alu_r = $signed(alu_b) >>> alu_a[4:0];
            default: alu_r = 32'h0000_0000;
        endcase
        alu_z = (alu_r == 32'h0000_0000);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        id;
        logic [3:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
    } vec_t;

    // Single-op transaction entered and left at a falling edge in IDLE
    task automatic run_op(input logic id, input logic [3:0] aluc, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input logic z);
        int n;
        rsp_ready = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_aluc = aluc; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_aluc = aluc; req0_a = a; req0_b = b;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 8) begin
            @(negedge clk); #1;
            n++;
        end
        check("op_ready", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
        check("op_other_ready", {31'd0, id ? req0_ready : req1_ready}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("exec_alu_aluc", {28'd0, alu_aluc}, {28'd0, aluc});
        check("exec_alu_a", alu_a, a);
        check("exec_alu_b", alu_b, b);
        @(negedge clk); #1;
        check("resp_valid", {31'd0, rsp_valid}, 32'd1);
        check("resp_id", {31'd0, rsp_id}, {31'd0, id});
        check("resp_r", rsp_r, r);
        check("resp_z", {31'd0, rsp_z}, {31'd0, z});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_rsp_r_held", rsp_r, r);
    endtask

    vec_t vecs[11];
    logic g;
    logic exp_g;

    initial begin
        vecs[0]  = '{1'b0, 4'b0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0};
        vecs[1]  = '{1'b1, 4'b0100, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{1'b0, 4'b0011, 32'h0000_000F, 32'hFFFF_FFFF, 32'hFFFF_8000, 1'b0};
        vecs[3]  = '{1'b1, 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        vecs[4]  = '{1'b0, 4'b0101, 32'h0000_FFFF, 32'h00FF_0000, 32'h00FF_FFFF, 1'b0};
        vecs[5]  = '{1'b1, 4'b0010, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b0, 4'b0110, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000, 1'b0};
        vecs[7]  = '{1'b1, 4'b0111, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0};
        vecs[8]  = '{1'b0, 4'b0100, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 4'b1111, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0};
        vecs[10] = '{1'b0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};

        clrn = 1'b0;
        req0_valid = 1'b0; req0_aluc = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_aluc = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
        rsp_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_rsp_r", rsp_r, 32'd0);
        clrn = 1'b1;
        @(negedge clk);

        // Both requesters valid from reset with the consumer always ready
        req0_valid = 1'b1; req0_aluc = 4'b0000; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_aluc = 4'b0000; req1_a = 32'd2; req1_b = 32'd2;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 1'b0;
`else
            exp_g = (i % 2 == 1);
`endif
            g = req1_ready;
            check("rr_any_ready", {31'd0, req0_ready | req1_ready}, 32'd1);
            check("rr_grant", {31'd0, g}, {31'd0, exp_g});
            @(negedge clk); #1;
            check("rr_exec_no_ready", {31'd0, req0_ready | req1_ready}, 32'd0);
            @(negedge clk); #1;
            check("rr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("rr_rsp_id", {31'd0, rsp_id}, {31'd0, g});
            check("rr_rsp_r", rsp_r, g ? 32'd4 : 32'd2);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].id, vecs[i].aluc, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].z);
        end

        // Consumer stalls five cycles; a waiting request must not be accepted meanwhile
        req0_valid = 1'b1; req0_aluc = 4'b1111; req0_a = 32'h10; req0_b = 32'hFFFF_FF00;
        #1;
        check("hold_accept", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_aluc = 4'b0000; req1_a = 32'd3; req1_b = 32'd4;
        #1;
        check("hold_exec_no_ready", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_r", rsp_r, 32'hFFFF_FFFF);
            check("hold_no_ready", {31'd0, req0_ready | req1_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("hold_release_ready", {31'd0, req1_ready}, 32'd1);
        check("hold_release_valid", {31'd0, rsp_valid}, 32'd0);
        check("hold_release_r_kept", rsp_r, 32'hFFFF_FFFF);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk); #1;
        check("hold_next_id", {31'd0, rsp_id}, 32'd1);
        check("hold_next_r", rsp_r, 32'd7);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset during EXEC drops the op and clears every register
        req0_valid = 1'b1; req0_aluc = 4'b0000; req0_a = 32'd7; req0_b = 32'd8;
        #1;
        check("mid_rst_accept", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        clrn = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_alu_a", alu_a, 32'd0);
        check("mid_rst_alu_b", alu_b, 32'd0);
        check("mid_rst_rsp_r", rsp_r, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk); #1;
        check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b1; req0_aluc = 4'b0000; req0_a = 32'd7; req0_b = 32'd8;
        req1_valid = 1'b1; req1_aluc = 4'b0100; req1_a = 32'd9; req1_b = 32'd1;
        #1;
        check("post_rst_grant0", {31'd0, req0_ready}, 32'd1);
        check("post_rst_no_grant1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk); #1;
        check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("post_rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("post_rst_rsp_r", rsp_r, 32'd15);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
